// File: rtl/passcode_entry.sv
// passcode_entry: turns raw board buttons and hex slide switches into the
// safe controller's input bus. Every button has its own synchronizer,
// debounce counter and rising-edge detector. Digit presses shift hex digits
// into a four-digit entry register. Commit and lock are issued as
// single-cycle strobes.
//
// state | meaning
// ------+-----------------------------------------
// IDLE  | no digits entered (count 0)
// ENTRY | partial entry (count 1..3)
// FULL  | four digits entered, commit is accepted
module passcode_entry #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_sw,
  input  logic        btn_digit,
  input  logic        btn_clear,
  input  logic        btn_set,
  input  logic        btn_commit,
  input  logic        btn_lock,
  output logic [15:0] passinput,
  output logic        pass_set,
  output logic        pass_reg,
  output logic        pass_lock,
  output logic [2:0]  digit_count,
  output logic        entry_full
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Button channel index: 0 digit, 1 clear, 2 set, 3 commit, 4 lock.
  localparam int B_DIGIT  = 0;
  localparam int B_CLEAR  = 1;
  localparam int B_SET    = 2;
  localparam int B_COMMIT = 3;
  localparam int B_LOCK   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

  logic [4:0]    btn_raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    deb;
  logic [4:0]    deb_d;
  logic [4:0]    press;
  logic [CW-1:0] cnt [5];

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   pass_nxt;
  logic [2:0]    count_nxt;
  logic          reg_nxt;
  logic          lock_nxt;

  assign btn_raw = {btn_lock, btn_commit, btn_set, btn_clear, btn_digit};

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: the level flips only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  // State and output registers. Every output is registered, so no input reaches an output combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      passinput   <= 16'h0000;
      digit_count <= 3'd0;
      entry_full  <= 1'b0;
      pass_reg    <= 1'b0;
      pass_lock   <= 1'b0;
      pass_set    <= 1'b0;
    end else begin
      state       <= state_nxt;
      passinput   <= pass_nxt;
      digit_count <= count_nxt;
      entry_full  <= (count_nxt == 3'd4);
      pass_reg    <= reg_nxt;
      pass_lock   <= lock_nxt;
      pass_set    <= deb[B_SET];
    end
  end

  // Next-state logic. Only the highest-priority press acts (lock > clear > commit > digit).
  always_comb begin
    state_nxt = state;
    pass_nxt  = passinput;
    count_nxt = digit_count;
    reg_nxt   = 1'b0;
    lock_nxt  = 1'b0;
    if (press[B_LOCK]) begin
      lock_nxt  = 1'b1;
      pass_nxt  = 16'h0000;
      count_nxt = 3'd0;
      state_nxt = IDLE;
    end else if (press[B_CLEAR]) begin
      pass_nxt  = 16'h0000;
      count_nxt = 3'd0;
      state_nxt = IDLE;
    end else if (press[B_COMMIT]) begin
      if (state == FULL) reg_nxt = 1'b1;
    end else if (press[B_DIGIT]) begin
      if (state != FULL) begin
        pass_nxt  = {passinput[11:0], digit_sw};
        count_nxt = digit_count + 3'd1;
        state_nxt = (digit_count == 3'd3) ? FULL : ENTRY;
      end
    end
  end

endmodule

// File: tb/tb_passcode_entry.sv
// Bench for passcode_entry with a short debounce. Every cycle the outputs are
// compared against a behavioural model. The model holds the recent raw button
// samples and the list of entered digits. Directed steps follow the safe's
// test plan, and a randomized phase follows them.
module tb_passcode_entry;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_sw;
  logic [4:0]  btns;
  logic        btn_digit, btn_clear, btn_set, btn_commit, btn_lock;
  logic [15:0] passinput;
  logic        pass_set, pass_reg, pass_lock;
  logic [2:0]  digit_count;
  logic        entry_full;

  assign btn_digit  = btns[0];
  assign btn_clear  = btns[1];
  assign btn_set    = btns[2];
  assign btn_commit = btns[3];
  assign btn_lock   = btns[4];

  always #5 clk = ~clk;

  passcode_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst         (rst),
    .digit_sw    (digit_sw),
    .btn_digit   (btn_digit),
    .btn_clear   (btn_clear),
    .btn_set     (btn_set),
    .btn_commit  (btn_commit),
    .btn_lock    (btn_lock),
    .passinput   (passinput),
    .pass_set    (pass_set),
    .pass_reg    (pass_reg),
    .pass_lock   (pass_lock),
    .digit_count (digit_count),
    .entry_full  (entry_full)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: m_hist[k] is the raw button vector sampled k+1 edges back.
  logic [4:0] m_hist [0:D];
  logic [4:0] m_deb;
  logic [4:0] m_deb_d;
  logic [3:0] m_digits [$];
  logic       m_set, m_reg, m_lock;

  int          reg_hits, lock_hits;
  logic [15:0] pass_at_lock;
  logic [2:0]  cnt_at_lock;

  function automatic logic [15:0] m_pass();
    logic [15:0] v;
    v = 16'h0000;
    foreach (m_digits[i]) v = {v[11:0], m_digits[i]};
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= D; k++) m_hist[k] = '0;
    m_deb   = '0;
    m_deb_d = '0;
    m_digits.delete();
    m_set  = 1'b0;
    m_reg  = 1'b0;
    m_lock = 1'b0;
  endtask

  // A level counts as settled once the raw samples from 2..D+1 edges back all disagree with it.
  task automatic model_step();
    logic [4:0] press, flip;
    if (rst) begin
      model_reset();
      return;
    end
    press = m_deb & ~m_deb_d;
    m_set = m_deb[2];
    for (int b = 0; b < 5; b++) begin
      flip[b] = 1'b1;
      for (int k = 1; k <= D; k++) if (m_hist[k][b] == m_deb[b]) flip[b] = 1'b0;
    end
    m_deb_d = m_deb;
    m_deb   = m_deb ^ flip;
    for (int k = D; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = btns;
    m_reg  = 1'b0;
    m_lock = 1'b0;
    if (press[4]) begin
      m_lock = 1'b1;
      m_digits.delete();
    end else if (press[1]) begin
      m_digits.delete();
    end else if (press[3]) begin
      if (m_digits.size() == 4) m_reg = 1'b1;
    end else if (press[0]) begin
      if (m_digits.size() < 4) m_digits.push_back(digit_sw);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("passinput",   passinput, m_pass());
    chk("digit_count", 16'(digit_count), 16'(m_digits.size()));
    chk("entry_full",  16'(entry_full), 16'(m_digits.size() == 4));
    chk("pass_set",    16'(pass_set), 16'(m_set));
    chk("pass_reg",    16'(pass_reg), 16'(m_reg));
    chk("pass_lock",   16'(pass_lock), 16'(m_lock));
    chk("reg_lock_excl", 16'(pass_reg & pass_lock), 16'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (pass_reg) reg_hits++;
    if (pass_lock) begin
      if (lock_hits == 0) begin
        pass_at_lock = passinput;
        cnt_at_lock  = digit_count;
      end
      lock_hits++;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hold(input logic [4:0] mask, input int cyc);
    btns = btns | mask;
    ticks(cyc);
    btns = btns & ~mask;
    ticks(10);
  endtask

  task automatic digit_latency(input logic [3:0] d);
    int lat;
    logic [2:0] c0;
    lat = 0;
    c0 = digit_count;
    digit_sw = d;
    btns[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (lat == 0 && digit_count != c0) lat = i;
    end
    btns[0] = 1'b0;
    ticks(10);
    chk("digit_latency", 16'(lat), 16'd7);
  endtask

  task automatic clear_watch();
    reg_hits  = 0;
    lock_hits = 0;
    pass_at_lock = 16'hxxxx;
    cnt_at_lock  = 3'bxxx;
  endtask

  initial begin
    int rise, fall, first_lock, first_set, r;
    logic [4:0] mask;
    rst = 1'b1;
    btns = '0;
    digit_sw = 4'h0;
    model_reset();
    clear_watch();
    ticks(3);
    rst = 1'b0;
    ticks(3);

    // Entry with per-press latency, then an ignored fifth press.
    digit_latency(4'h1);
    digit_latency(4'h2);
    digit_latency(4'h3);
    digit_latency(4'h4);
    chk("entry_pass", passinput, 16'h1234);
    chk("entry_count", 16'(digit_count), 16'd4);
    chk("entry_full_flag", 16'(entry_full), 16'd1);
    digit_sw = 4'h9;
    hold(5'b00001, 12);
    chk("fifth_ignored", passinput, 16'h1234);

    // Clear, then a bounced press that must not register and a clean 12-cycle hold.
    hold(5'b00010, 12);
    chk("clear_count", 16'(digit_count), 16'd0);
    digit_sw = 4'h7;
    btns[0] = 1'b1; ticks(3);
    btns[0] = 1'b0; ticks(2);
    btns[0] = 1'b1; ticks(2);
    btns[0] = 1'b0; ticks(10);
    chk("bounce_count", 16'(digit_count), 16'd0);
    digit_sw = 4'h1;
    hold(5'b00001, 12);
    chk("hold_one_shift", passinput, 16'h0001);
    chk("hold_one_count", 16'(digit_count), 16'd1);

    // Commit is ignored with three digits and accepted with four.
    digit_sw = 4'h2; hold(5'b00001, 12);
    digit_sw = 4'h3; hold(5'b00001, 12);
    chk("three_digits", passinput, 16'h0123);
    clear_watch();
    hold(5'b01000, 12);
    chk("commit_partial", 16'(reg_hits), 16'd0);
    digit_sw = 4'h4; hold(5'b00001, 12);
    chk("four_digits", passinput, 16'h1234);
    clear_watch();
    hold(5'b01000, 12);
    chk("commit_full", 16'(reg_hits), 16'd1);
    chk("commit_keeps", passinput, 16'h1234);

    // Lock in FULL clears the entry on the same edge as the strobe.
    clear_watch();
    hold(5'b10000, 12);
    chk("lock_hits", 16'(lock_hits), 16'd1);
    chk("lock_pass", pass_at_lock, 16'h0000);
    chk("lock_count", 16'(cnt_at_lock), 16'd0);

    // Clear and digit together: clear wins.
    digit_sw = 4'h5; hold(5'b00001, 12);
    digit_sw = 4'h6; hold(5'b00011, 12);
    chk("clear_beats_digit", 16'(digit_count), 16'd0);

    // Lock and commit together in FULL: only the lock strobe.
    for (int i = 0; i < 4; i++) begin
      digit_sw = 4'($urandom_range(0, 15));
      hold(5'b00001, 12);
    end
    clear_watch();
    hold(5'b11000, 12);
    chk("lockcommit_reg", 16'(reg_hits), 16'd0);
    chk("lockcommit_lock", 16'(lock_hits), 16'd1);

    // Set level follows the debounced button with the press latency both ways.
    digit_sw = 4'hA; hold(5'b00001, 12);
    rise = 0;
    btns[2] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rise == 0 && pass_set) rise = i;
    end
    btns[2] = 1'b0;
    fall = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (fall == 0 && !pass_set) fall = i;
    end
    chk("set_rise", 16'(rise), 16'd7);
    chk("set_fall", 16'(fall), 16'd7);
    chk("set_pass_kept", passinput, 16'h000A);

    // Reset mid-debounce with every button held, then release reset while the buttons stay held.
    btns = 5'b11111;
    ticks(4);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pass", passinput, 16'h0000);
    chk("rst_count", 16'(digit_count), 16'd0);
    chk("rst_flags", 16'({pass_set, pass_reg, pass_lock, entry_full}), 16'h0);
    ticks(2);
    rst = 1'b0;
    first_lock = 0;
    first_set = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (first_lock == 0 && pass_lock) first_lock = i;
      if (first_set == 0 && pass_set) first_set = i;
    end
    chk("post_rst_lock_edge", 16'(first_lock), 16'd7);
    chk("post_rst_set_edge", 16'(first_set), 16'd7);
    btns = '0;
    ticks(12);

    // Randomized presses with occasional short glitches and multi-button combinations.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 4, 5: mask = 5'b00001;
        6:                mask = 5'b00010;
        7:                mask = 5'b01000;
        8:                mask = 5'b10000;
        default:          mask = 5'($urandom_range(1, 31));
      endcase
      digit_sw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        btns = btns | mask;
        ticks(int'($urandom_range(1, 3)));
        btns = btns & ~mask;
        ticks(2);
      end
      hold(mask, int'($urandom_range(10, 14)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
